// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register family.
// Occupancy encodings mirror the {main_v, skid_v} flag pair directly.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_ONE   = 2'b10,
        PIPE_TWO   = 2'b11
    } pipe_occ_e;

    localparam int PIPE_CNT_W  = 32;
    localparam int PIPE_WORD_W = 32;

    // The (0,1) pair cannot be reached; it decodes as EMPTY so the stage drains to a sane state.
    function automatic pipe_occ_e occ_from_flags(input logic main_v, input logic skid_v);
        case ({main_v, skid_v})
            2'b10:   return PIPE_ONE;
            2'b11:   return PIPE_TWO;
            default: return PIPE_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Optional stall cycle counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WORD_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data
`ifdef PIPE_STALL_CNT_EN
   ,output logic [PIPE_CNT_W-1:0] stall_cnt
`endif
);

    logic             main_v_q,    main_v_d;
    logic             skid_v_q,    skid_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    logic      accept;
    logic      deliver;
    pipe_occ_e occ;

    // in_ready comes straight from a flop so no combinational path reaches upstream.
    assign in_ready  = !skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;
    assign occ     = occ_from_flags(main_v_q, skid_v_q);

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_data_d = RESET_VAL;
            skid_data_d = RESET_VAL;
        end else begin
            case (occ)
                PIPE_EMPTY: begin
                    if (accept) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                    end
                end
                PIPE_ONE: begin
                    if (accept && deliver) begin
                        main_data_d = in_data;
                    end else if (accept) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                    end else if (deliver) begin
                        main_v_d = 1'b0;
                    end
                end
                PIPE_TWO: begin
                    if (deliver) begin
                        main_data_d = skid_data_q;
                        skid_v_d    = 1'b0;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= RESET_VAL;
            skid_data_q <= RESET_VAL;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic stall_clear;
    logic stall_inc;

    // Flush deliberately leaves the count alone; only reset clears it.
    assign stall_clear = !reset;
    assign stall_inc   = main_v_q & !out_ready;

    sat_counter #(
        .W (PIPE_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (stall_clear),
        .inc   (stall_inc),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: scoreboard of accepted words versus delivered words,
// plus directed checks of reset, streaming, skid fill, flush and the optional stall counter.
module tb_pipe_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_q[$];

    pipe_skid_reg #(
        .WIDTH     (32),
        .RESET_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle: state before the coming edge must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            check_val("occ_out_valid", out_valid, sb_q.size() != 0);
            check_val("occ_in_ready", in_ready, sb_q.size() < 2);
            if (out_valid) begin
                if (sb_q.size() == 0) check_val("valid_with_empty_sb", 1'b1, 1'b0);
                else                  check_val("out_data_order", out_data, sb_q[0]);
            end
            if (out_valid && out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
            if (flush)                      sb_q.delete();
            else if (in_valid && in_ready)  sb_q.push_back(in_data);
        end
    end

    task automatic send_two_held(input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        step();
        in_data   = b;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;

        // 1. Reset holds the stage empty despite in_valid.
        repeat (2) step();
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_out_data", out_data, 32'h0);
        reset = 1'b1;
        step();
        check_val("first_out_valid", out_valid, 1'b1);
        check_val("first_out_data", out_data, 32'hDEAD_BEEF);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_val("first_drained", out_valid, 1'b0);

        // 2. Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            check_val("stream_in_ready", in_ready, 1'b1);
            check_val("stream_out_valid", out_valid, 1'b1);
            check_val("stream_out_data", out_data, 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_val("stream_drained", out_valid, 1'b0);

        // 3. Skid fill and drain.
        send_two_held(32'hA, 32'hB);
        check_val("skid_in_ready", in_ready, 1'b0);
        check_val("skid_out_data", out_data, 32'hA);
        step();
        check_val("skid_hold_data", out_data, 32'hA);
        check_val("skid_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        check_val("skid_ready_back", in_ready, 1'b1);
        check_val("skid_second", out_data, 32'hB);
        step();
        check_val("skid_drained", out_valid, 1'b0);

        // 4. Flush while two entries are held, with a competing accept.
        send_two_held(32'hA, 32'hB);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hC;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("flush_out_valid", out_valid, 1'b0);
        check_val("flush_out_data", out_data, 32'h0);
        check_val("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) step();
        check_val("flush_no_stale", out_valid, 1'b0);

        // 5. Reset while in TWO.
        send_two_held(32'h11, 32'h22);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_val("mid_rst_out_valid", out_valid, 1'b0);
        check_val("mid_rst_in_ready", in_ready, 1'b1);
        check_val("mid_rst_out_data", out_data, 32'h0);
        out_ready = 1'b1;
        repeat (3) step();
        check_val("mid_rst_no_stale", out_valid, 1'b0);

`ifdef PIPE_STALL_CNT_EN
        // 6. Stall counter: five stalled cycles, the last one being the flush cycle.
        check_val("cnt_after_rst", stall_cnt, 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        step();
        in_valid  = 1'b0;
        check_val("cnt_before_stall", stall_cnt, 32'd0);
        repeat (4) step();
        check_val("cnt_four", stall_cnt, 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("cnt_five", stall_cnt, 32'd5);
        repeat (2) step();
        check_val("cnt_kept_after_flush", stall_cnt, 32'd5);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_val("cnt_cleared", stall_cnt, 32'd0);
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
